s2_s18_gearbox_ctrl: RTL and testbench

Single-clock 2-bit-to-16-bit width-converting FIFO controller that drives a 2-bit / 18-bit dual-port block RAM (port A 8192×2 write-only, port B 1024×18 read-only). Upstream logic streams 2-bit symbols into port A. The controller packs them into 16-bit words, read through port B with prefetch into a 2-entry output buffer. Downstream receives a valid/ready word stream. The controller owns all RAM address, enable and write-enable generation. The RAM instance sits beside it in the same wrapper.

---
 rtl/s2_s18_gearbox_ctrl_pkg.sv | 11 +
 rtl/s2_s18_gearbox_ctrl_out_buf.sv | 26 ++
 rtl/s2_s18_gearbox_ctrl.sv | 65 ++++++
 tb/tb_s2_s18_gearbox_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/s2_s18_gearbox_ctrl_pkg.sv
// gearbox_pkg: geometry constants and symbol packing helper for the 2-to-16 gearbox
package gearbox_pkg;
  localparam int SYM_PER_WORD = 8;
  localparam int ADDRA_W = 13;
  localparam int ADDRB_W = 10;
  localparam int PTR_A_W = 14;
  localparam int PTR_B_W = 11;
  function automatic logic [3:0] sym_bit_off(input logic [2:0] k);
    return {k, 1'b0};
  endfunction
endpackage

// File: rtl/s2_s18_gearbox_ctrl_out_buf.sv
// s18_out_buf: 2-entry word buffer, head at e0, simultaneous push and pop
module s18_out_buf (
  input  logic        CLK,
  input  logic        SSR,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] din,
  output logic [1:0]  count,
  output logic [15:0] head
);
  logic [1:0] cnt_q, cnt_d, left;
  logic [15:0] e0_q, e0_d, e1_q, e1_d;
  always_comb begin
    left = cnt_q - {1'b0, pop};
    cnt_d = left + {1'b0, push};
    e0_d = (pop && cnt_q == 2'd2) ? e1_q : (push && left == 2'd0) ? din : e0_q;
    e1_d = (push && left == 2'd1) ? din : e1_q;
  end
  always_ff @(posedge CLK) begin
    cnt_q <= SSR ? 2'd0 : cnt_d;
    e0_q <= e0_d;
    e1_q <= e1_d;
  end
  assign count = cnt_q;
  assign head = e0_q;
endmodule

// File: rtl/s2_s18_gearbox_ctrl.sv
// s2_s18_gearbox_ctrl: packs 2-bit symbols into 16-bit words through a 2/18-bit dual-port RAM
module s2_s18_gearbox_ctrl
  import gearbox_pkg::*;
(
  input  logic                CLK,
  input  logic                SSR,
  input  logic                s_valid,
  input  logic [1:0]          s_data,
  output logic                s_ready,
  output logic                m_valid,
  output logic [15:0]         m_data,
  input  logic                m_ready,
  output logic [PTR_A_W-1:0]  sym_level,
  output logic [ADDRA_W-1:0]  ram_addra,
  output logic [1:0]          ram_dia,
  output logic                ram_ena,
  output logic                ram_wea,
  output logic [ADDRB_W-1:0]  ram_addrb,
  output logic                ram_enb,
  input  logic [15:0]         ram_dob
);
  logic [PTR_A_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_B_W-1:0] rd_ptr_q, rd_ptr_d, avail;
  logic inflight_q, inflight_d, wr_en, issue, pop;
  logic [1:0] count;
  // only whole words count as readable; the partial word stays on port A's side
  always_comb begin
    sym_level = wr_ptr_q - {rd_ptr_q, 3'b000};
    avail = wr_ptr_q[PTR_A_W-1:3] - rd_ptr_q;
    pop = m_valid & m_ready;
    s_ready = (sym_level != 14'd8192) & !SSR;
    wr_en = s_valid & s_ready;
    issue = (avail != '0) & (({1'b0, count} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop})) & !SSR;
    wr_ptr_d = wr_ptr_q + {{(PTR_A_W-1){1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{(PTR_B_W-1){1'b0}}, issue};
    inflight_d = issue;
    ram_ena = wr_en;
    ram_wea = wr_en;
    ram_addra = wr_ptr_q[ADDRA_W-1:0];
    ram_dia = s_data;
    ram_enb = issue;
    ram_addrb = rd_ptr_q[ADDRB_W-1:0];
  end
  always_ff @(posedge CLK) begin
    if (SSR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      inflight_q <= inflight_d;
    end
  end
  s18_out_buf u_buf (
    .CLK   (CLK),
    .SSR   (SSR),
    .push  (inflight_q),
    .pop   (pop),
    .din   (ram_dob),
    .count (count),
    .head  (m_data)
  );
  assign m_valid = count != 2'd0;
endmodule

// File: tb/tb_s2_s18_gearbox_ctrl.sv
// tb_s2_s18_gearbox_ctrl: vector table, corner sequences and a symbol-queue scoreboard
module tb_s2_s18_gearbox_ctrl;
  logic CLK = 1'b0, SSR = 1'b1, s_valid = 1'b0, m_ready = 1'b0;
  logic [1:0] s_data = 2'd0;
  logic s_ready, m_valid, ram_ena, ram_wea, ram_enb;
  logic [15:0] m_data, ram_dob;
  logic [13:0] sym_level;
  logic [12:0] ram_addra;
  logic [1:0] ram_dia;
  logic [9:0] ram_addrb;
  logic [15:0] ram [1024];

  s2_s18_gearbox_ctrl dut (
    .CLK(CLK), .SSR(SSR), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .sym_level(sym_level),
    .ram_addra(ram_addra), .ram_dia(ram_dia), .ram_ena(ram_ena), .ram_wea(ram_wea),
    .ram_addrb(ram_addrb), .ram_enb(ram_enb), .ram_dob(ram_dob)
  );

  initial forever #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (ram_ena && ram_wea) ram[ram_addra[12:3]][{ram_addra[2:0], 1'b0} +: 2] <= ram_dia;
    if (ram_enb) ram_dob <= ram[ram_addrb];
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: every accepted symbol joins a word; words leave in order
  int written = 0, issued = 0, delivered = 0, nacc = 0;
  logic [15:0] acc_w;
  logic [15:0] expq [$];
  always @(negedge CLK) begin
    if (SSR) begin
      written = 0; issued = 0; delivered = 0; nacc = 0;
      expq.delete();
    end else begin
      chk("sym_level", 32'(sym_level), written - 8 * issued);
      if (ram_enb) begin
        chk("addrb", 32'(ram_addrb), issued % 1024);
        chk("issue_whole_word", 32'(issued < written / 8), 32'd1);
        issued++;
      end
      if (s_valid && s_ready) begin
        chk("addra", 32'(ram_addra), written % 8192);
        chk("ena_wea", 32'({ram_ena, ram_wea}), 32'd3);
        chk("dia", 32'(ram_dia), 32'(s_data));
        acc_w[2 * nacc +: 2] = s_data;
        nacc++;
        written++;
        if (nacc == 8) begin
          expq.push_back(acc_w);
          nacc = 0;
        end
      end
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL m_data: got %0h expected no word at %0t", m_data, $time);
        end else chk("m_data", 32'(m_data), 32'(expq.pop_front()));
        delivered++;
      end
      chk("occupancy", 32'(issued - delivered <= 2), 32'd1);
    end
  end

  typedef struct {
    logic ssr, sv;
    logic [1:0] sd;
    logic mr, e_mv;
    logic [15:0] e_md;
    logic [13:0] e_lvl;
    logic e_sr, e_enb;
  } vec_t;
  vec_t tbl [13];

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    SSR = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    cyc();
    SSR = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input int lim);
    logic ok;
    ok = 1'b0;
    cyc();
    m_ready = 1'b1; s_valid = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge CLK);
      #1;
      if (expq.size() == 0 && sym_level < 14'd8) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    chk({nm, "_drained"}, 32'(ok), 32'd1);
    cyc();
    @(negedge CLK);
    chk({nm, "_idle_mv"}, 32'(m_valid), 32'd0);
    chk({nm, "_left"}, 32'(expq.size()), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, accepted, stall;
    logic hit;
    cyc();
    tbl[0] = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 16'h0, 14'd0, 1'b0, 1'b0};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{1'b0, 1'b1, 2'((i - 1) % 4), 1'b1, 1'b0, 16'h0, 14'(i - 1), 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 16'h0, 14'd8, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 16'h0, 14'd0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 16'hE4E4, 14'd0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 16'h0, 14'd0, 1'b1, 1'b0};
    for (int i = 0; i < 13; i++) begin
      cyc();
      SSR = tbl[i].ssr; s_valid = tbl[i].sv; s_data = tbl[i].sd; m_ready = tbl[i].mr;
      @(negedge CLK);
      chk($sformatf("tbl%0d_mv", i), 32'(m_valid), 32'(tbl[i].e_mv));
      if (tbl[i].e_mv) chk($sformatf("tbl%0d_md", i), 32'(m_data), 32'(tbl[i].e_md));
      chk($sformatf("tbl%0d_lvl", i), 32'(sym_level), 32'(tbl[i].e_lvl));
      chk($sformatf("tbl%0d_srdy", i), 32'(s_ready), 32'(tbl[i].e_sr));
      chk($sformatf("tbl%0d_enb", i), 32'(ram_enb), 32'(tbl[i].e_enb));
    end

    // partial word never becomes readable; 8th symbol completes it
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      s_valid = 1'b1; s_data = 2'($urandom);
    end
    cyc();
    s_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("partial_mv", 32'(m_valid), 32'd0);
      cyc();
    end
    @(negedge CLK);
    chk("partial_lvl", 32'(sym_level), 32'd7);
    cyc();
    s_valid = 1'b1; s_data = 2'($urandom);
    cyc();
    s_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      n++;
      if (m_valid) break;
      cyc();
    end
    chk("latency", 32'(n), 32'd3);
    wait_drain("partial", 20);

    // fill the RAM with the consumer stalled
    do_reset();
    accepted = 0; hit = 1'b0;
    for (int i = 0; i < 9000; i++) begin
      cyc();
      s_valid = 1'b1; s_data = 2'($urandom); m_ready = 1'b0;
      @(negedge CLK);
      if (!s_ready) begin
        hit = 1'b1;
        break;
      end
      accepted++;
    end
    chk("full_hit", 32'(hit), 32'd1);
    chk("full_accepted", 32'(accepted), 32'd8208);
    chk("full_lvl", 32'(sym_level), 32'd8192);
    chk("full_mv", 32'(m_valid), 32'd1);
    cyc();
    m_ready = 1'b1;
    @(negedge CLK);
    chk("full_blocked", 32'(s_ready), 32'd0);
    chk("full_issue", 32'(ram_enb), 32'd1);
    cyc();
    m_ready = 1'b0; s_valid = 1'b0;
    @(negedge CLK);
    chk("full_lvl_after", 32'(sym_level), 32'd8184);
    chk("full_srdy_after", 32'(s_ready), 32'd1);
    wait_drain("full", 3000);

    // full-rate streaming across pointer wrap
    do_reset();
    stall = 0;
    for (int i = 0; i < 20000; i++) begin
      cyc();
      s_valid = 1'b1; s_data = 2'($urandom); m_ready = 1'b1;
      @(negedge CLK);
      if (!s_ready) stall++;
    end
    wait_drain("stream", 50);
    chk("stream_stalls", 32'(stall), 32'd0);
    chk("stream_words", 32'(delivered), 32'd2500);

    // random backpressure
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cyc();
      s_valid = 1'b1; s_data = 2'($urandom); m_ready = ($urandom_range(0, 99) < 30);
    end
    wait_drain("rand", 3000);
    chk("rand_words", 32'(delivered), 32'(written / 8));

    // reset with a read in flight and a word buffered
    do_reset();
    for (int i = 0; i < 24; i++) begin
      cyc();
      s_valid = 1'b1; s_data = 2'($urandom);
    end
    cyc();
    s_valid = 1'b0;
    repeat (10) cyc();
    @(negedge CLK);
    chk("pre_rst_mv", 32'(m_valid), 32'd1);
    chk("pre_rst_lvl", 32'(sym_level), 32'd8);
    cyc();
    m_ready = 1'b1;
    @(negedge CLK);
    chk("pre_rst_issue", 32'(ram_enb), 32'd1);
    cyc();
    m_ready = 1'b0; SSR = 1'b1;
    @(negedge CLK);
    chk("in_rst_srdy", 32'(s_ready), 32'd0);
    cyc();
    SSR = 1'b0;
    @(negedge CLK);
    chk("post_rst_mv", 32'(m_valid), 32'd0);
    chk("post_rst_lvl", 32'(sym_level), 32'd0);
    chk("post_rst_srdy", 32'(s_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      s_valid = 1'b1; s_data = 2'($urandom);
    end
    cyc();
    s_valid = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (ram_enb) begin
        chk("post_rst_addrb", 32'(ram_addrb), 32'd0);
        hit = 1'b1;
        break;
      end
      cyc();
    end
    chk("post_rst_issue", 32'(hit), 32'd1);
    wait_drain("post_rst", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
